// File: rtl/ccip_mem_responder.sv
// ccip_mem_responder: host-memory side of a CCI-P link. Queues AFU read (c0)
// and write (c1) requests, services them from a line-addressed memory and
// returns RDLINE/WRLINE responses. Includes a backdoor port for preloading
// and inspecting lines.

package ccip_if_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4} t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         hit_miss;
    logic         format;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         hit_miss;
    logic         format;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

// Request FIFO with registered almost-full. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module ccip_mem_responder_fifo #(
  parameter int WIDTH          = 58,
  parameter int DEPTH          = 64,
  parameter int ALM_FULL_SLACK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             alm_full,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count;
  logic             full, do_pop, do_push, alm_full_reg;

  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign dout     = store[rd_ptr_reg[AW-1:0]];
  assign alm_full = alm_full_reg;

  // Entry storage (not reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr_reg[AW-1:0]] <= din;
  end

  // Pointers and almost-full flag, threshold judged on current occupancy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      alm_full_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      alm_full_reg <= (count >= (AW+1)'(DEPTH - ALM_FULL_SLACK));
    end
  end
endmodule

module ccip_mem_responder
  import ccip_if_pkg::*;
#(
  parameter int           MEM_LINES      = 1024,
  parameter t_ccip_clAddr MEM_BASE       = '0,
  parameter int           RD_LATENCY     = 8,
  parameter int           REQ_FIFO_DEPTH = 64,
  parameter int           ALM_FULL_SLACK = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  t_if_ccip_c0_Tx               ccip_c0_tx,
  input  t_if_ccip_c1_Tx               ccip_c1_tx,
  input  logic                         rsp_stall,
  output t_if_ccip_Rx                  ccip_rx,
  input  logic                         bd_wr_en,
  input  logic                         bd_rd_en,
  input  logic [$clog2(MEM_LINES)-1:0] bd_addr,
  input  logic [511:0]                 bd_wdata,
  output logic [511:0]                 bd_rdata,
  output logic [31:0]                  rd_cnt,
  output logic [31:0]                  wr_cnt,
  output logic [2:0]                   err_flags
);
  localparam int IW = $clog2(MEM_LINES);

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
  } t_c1_entry;

  t_ccip_clData       mem [MEM_LINES];
  t_ccip_c0_ReqMemHdr c0_head;
  t_c1_entry          c1_head, c1_push_entry;
  logic               c0_empty, c1_empty, c0_alm, c1_alm, c0_ovf, c1_ovf;
  logic               c0_pop, c1_pop, c0_in_win, c1_in_win, c1_wr;
  t_ccip_clAddr       c0_off, c1_off;
  logic [IW-1:0]      c0_idx, c1_idx;
  t_ccip_clData       c0_line, bd_line;

  logic               pipe_v_reg     [RD_LATENCY];
  t_ccip_mdata        pipe_mdata_reg [RD_LATENCY];
  t_ccip_clData       pipe_data_reg  [RD_LATENCY];
  logic               c1_v_reg;
  t_ccip_mdata        c1_mdata_reg;
  logic               c0_fire, c1_fire;
  logic [31:0]        rd_cnt_reg, wr_cnt_reg;
  logic [2:0]         err_reg;
  logic [511:0]       bd_rdata_reg;

  assign c1_push_entry = '{hdr: ccip_c1_tx.hdr, data: ccip_c1_tx.data};

  ccip_mem_responder_fifo #(
    .WIDTH($bits(t_ccip_c0_ReqMemHdr)), .DEPTH(REQ_FIFO_DEPTH), .ALM_FULL_SLACK(ALM_FULL_SLACK)
  ) u_c0_fifo (
    .clk(clk), .reset_n(reset_n), .push(ccip_c0_tx.valid), .pop(c0_pop),
    .din(ccip_c0_tx.hdr), .dout(c0_head), .empty(c0_empty), .alm_full(c0_alm), .overflow(c0_ovf)
  );

  ccip_mem_responder_fifo #(
    .WIDTH($bits(t_c1_entry)), .DEPTH(REQ_FIFO_DEPTH), .ALM_FULL_SLACK(ALM_FULL_SLACK)
  ) u_c1_fifo (
    .clk(clk), .reset_n(reset_n), .push(ccip_c1_tx.valid), .pop(c1_pop),
    .din(c1_push_entry), .dout(c1_head), .empty(c1_empty), .alm_full(c1_alm), .overflow(c1_ovf)
  );

  // Dequeue and window decode; an address below MEM_BASE wraps to a huge offset
  assign c0_pop    = !rsp_stall && !c0_empty;
  assign c1_pop    = !rsp_stall && !c1_empty;
  assign c0_off    = c0_head.address - MEM_BASE;
  assign c1_off    = c1_head.hdr.address - MEM_BASE;
  assign c0_in_win = (c0_off < t_ccip_clAddr'(MEM_LINES));
  assign c1_in_win = (c1_off < t_ccip_clAddr'(MEM_LINES));
  assign c0_idx    = c0_off[IW-1:0];
  assign c1_idx    = c1_off[IW-1:0];
  assign c1_wr     = c1_pop && c1_in_win;

  // Write-first read data: c1 beats backdoor, both beat stored contents
  always_comb begin
    c0_line = mem[c0_idx];
    if (bd_wr_en && bd_addr == c0_idx) c0_line = bd_wdata;
    if (c1_wr && c1_idx == c0_idx)     c0_line = c1_head.data;
    if (!c0_in_win)                    c0_line = '0;
    bd_line = mem[bd_addr];
    if (bd_wr_en)                      bd_line = bd_wdata;
    if (c1_wr && c1_idx == bd_addr)    bd_line = c1_head.data;
  end

  // Line memory; the later c1 write overrides a same-index backdoor write
  always_ff @(posedge clk) begin
    if (bd_wr_en) mem[bd_addr] <= bd_wdata;
    if (c1_wr)    mem[c1_idx]  <= c1_head.data;
  end

  // Read pipeline of RD_LATENCY stages, frozen in place while stalled
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v_reg[i]     <= 1'b0;
        pipe_mdata_reg[i] <= '0;
        pipe_data_reg[i]  <= '0;
      end
    end else if (!rsp_stall) begin
      pipe_v_reg[0] <= c0_pop;
      if (c0_pop) begin
        pipe_mdata_reg[0] <= c0_head.mdata;
        pipe_data_reg[0]  <= c0_line;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v_reg[i]     <= pipe_v_reg[i-1];
        pipe_mdata_reg[i] <= pipe_mdata_reg[i-1];
        pipe_data_reg[i]  <= pipe_data_reg[i-1];
      end
    end
  end

  // Write response register, held while stalled so no response is lost
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c1_v_reg     <= 1'b0;
      c1_mdata_reg <= '0;
    end else if (!rsp_stall) begin
      c1_v_reg <= c1_pop;
      if (c1_pop) c1_mdata_reg <= c1_head.hdr.mdata;
    end
  end

  assign c0_fire = pipe_v_reg[RD_LATENCY-1] && !rsp_stall;
  assign c1_fire = c1_v_reg && !rsp_stall;

  // Response counters, sticky error flags and backdoor read register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
      err_reg      <= '0;
      bd_rdata_reg <= '0;
    end else begin
      if (c0_fire) rd_cnt_reg <= rd_cnt_reg + 32'd1;
      if (c1_fire) wr_cnt_reg <= wr_cnt_reg + 32'd1;
      err_reg <= err_reg | {(c0_pop && !c0_in_win) || (c1_pop && !c1_in_win), c1_ovf, c0_ovf};
      if (bd_rd_en) bd_rdata_reg <= bd_line;
    end
  end

  // Assemble the receive-side response bundle
  always_comb begin
    ccip_rx                    = '0;
    ccip_rx.c0TxAlmFull        = c0_alm;
    ccip_rx.c1TxAlmFull        = c1_alm;
    ccip_rx.c0.rspValid        = c0_fire;
    ccip_rx.c0.hdr.resp_type   = eRSP_RDLINE;
    ccip_rx.c0.hdr.mdata       = pipe_mdata_reg[RD_LATENCY-1];
    ccip_rx.c0.data            = pipe_data_reg[RD_LATENCY-1];
    ccip_rx.c1.rspValid        = c1_fire;
    ccip_rx.c1.hdr.resp_type   = eRSP_WRLINE;
    ccip_rx.c1.hdr.mdata       = c1_mdata_reg;
  end

  assign bd_rdata  = bd_rdata_reg;
  assign rd_cnt    = rd_cnt_reg;
  assign wr_cnt    = wr_cnt_reg;
  assign err_flags = err_reg;
endmodule

// File: tb/tb_ccip_mem_responder.sv
// Directed bench for ccip_mem_responder: reset state, read latency, write
// response, backpressure/overflow, write-before-read, out-of-window access
// and reset with requests in flight.
module tb_ccip_mem_responder;
    import ccip_if_pkg::*;

    localparam int           MEM_LINES = 1024;
    localparam t_ccip_clAddr BASE      = 42'h100;

    logic           clk = 1'b0;
    logic           reset_n;
    t_if_ccip_c0_Tx c0_tx;
    t_if_ccip_c1_Tx c1_tx;
    logic           rsp_stall;
    t_if_ccip_Rx    rx;
    logic           bd_wr_en, bd_rd_en;
    logic [9:0]     bd_addr;
    logic [511:0]   bd_wdata, bd_rdata;
    logic [31:0]    rd_cnt, wr_cnt;
    logic [2:0]     err_flags;

    int             total, bad, got, found_at, n_rsp;
    logic [511:0]   pat_a5, pat_33, pat_c3;

    ccip_mem_responder #(
        .MEM_LINES(MEM_LINES), .MEM_BASE(BASE), .RD_LATENCY(8), .REQ_FIFO_DEPTH(64), .ALM_FULL_SLACK(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ccip_c0_tx(c0_tx), .ccip_c1_tx(c1_tx), .rsp_stall(rsp_stall),
        .ccip_rx(rx), .bd_wr_en(bd_wr_en), .bd_rd_en(bd_rd_en), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; rsp_stall = 1'b0; c0_tx = '0; c1_tx = '0;
        bd_wr_en = 1'b0; bd_rd_en = 1'b0; bd_addr = '0; bd_wdata = '0;
        pat_a5 = {64{8'hA5}}; pat_33 = {64{8'h33}}; pat_c3 = {64{8'hC3}};
        repeat (3) tick();

        total++; if (rx.c0.rspValid !== 1'b0) begin bad++; $display("FAIL rst_c0_valid: observed=%0h expected=0", rx.c0.rspValid); end
        total++; if (rx.c1.rspValid !== 1'b0) begin bad++; $display("FAIL rst_c1_valid: observed=%0h expected=0", rx.c1.rspValid); end
        total++; if (rx.c0.data !== 512'h0) begin bad++; $display("FAIL rst_c0_data: observed=%0h expected=0", rx.c0.data); end
        total++; if ({rx.c0TxAlmFull, rx.c1TxAlmFull} !== 2'b00) begin bad++; $display("FAIL rst_almfull: observed=%0h expected=0", {rx.c0TxAlmFull, rx.c1TxAlmFull}); end
        total++; if (rd_cnt !== 32'd0) begin bad++; $display("FAIL rst_rd_cnt: observed=%0h expected=0", rd_cnt); end
        total++; if (wr_cnt !== 32'd0) begin bad++; $display("FAIL rst_wr_cnt: observed=%0h expected=0", wr_cnt); end
        total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL rst_err: observed=%0h expected=0", err_flags); end
        total++; if (bd_rdata !== 512'h0) begin bad++; $display("FAIL rst_bd_rdata: observed=%0h expected=0", bd_rdata); end
        $display("txn reset checked");
        reset_n = 1'b1;

        bd_wr_en = 1'b1; bd_addr = 10'd5; bd_wdata = pat_a5; tick();
        bd_addr = 10'd3; bd_wdata = pat_33; tick();
        bd_wr_en = 1'b0; bd_wdata = '0;
        $display("txn preload lines 5 and 3");

        c0_tx.valid = 1'b1; c0_tx.hdr.address = BASE + 42'd5; c0_tx.hdr.mdata = 16'h12;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) c0_tx = '0;
            total++;
            if (rx.c0.rspValid !== (k == 9)) begin
                bad++; $display("FAIL rd_valid_timing: observed=%0h expected=%0h at k=%0d", rx.c0.rspValid, (k == 9), k);
            end
        end
        total++; if (rx.c0.data !== pat_a5) begin bad++; $display("FAIL rd_data: observed=%0h expected=%0h", rx.c0.data, pat_a5); end
        total++; if (rx.c0.hdr.mdata !== 16'h12) begin bad++; $display("FAIL rd_mdata: observed=%0h expected=12", rx.c0.hdr.mdata); end
        total++; if (rx.c0.hdr.resp_type !== eRSP_RDLINE) begin bad++; $display("FAIL rd_type: observed=%0h expected=%0h", rx.c0.hdr.resp_type, eRSP_RDLINE); end
        total++; if ({rx.c0.hdr.cl_num, rx.c0.hdr.format} !== 3'b000) begin bad++; $display("FAIL rd_clnum_fmt: observed=%0h expected=0", {rx.c0.hdr.cl_num, rx.c0.hdr.format}); end
        tick();
        total++; if (rx.c0.rspValid !== 1'b0) begin bad++; $display("FAIL rd_valid_once: observed=%0h expected=0", rx.c0.rspValid); end
        total++; if (rd_cnt !== 32'd1) begin bad++; $display("FAIL rd_cnt_1: observed=%0h expected=1", rd_cnt); end
        $display("txn read line 5 mdata 12");

        c1_tx.valid = 1'b1; c1_tx.hdr.address = BASE + 42'd7; c1_tx.hdr.mdata = 16'h34; c1_tx.data = 512'h1;
        tick();
        c1_tx = '0;
        total++; if (rx.c1.rspValid !== 1'b0) begin bad++; $display("FAIL wr_valid_early: observed=%0h expected=0", rx.c1.rspValid); end
        tick();
        total++; if (rx.c1.rspValid !== 1'b1) begin bad++; $display("FAIL wr_valid: observed=%0h expected=1", rx.c1.rspValid); end
        total++; if (rx.c1.hdr.mdata !== 16'h34) begin bad++; $display("FAIL wr_mdata: observed=%0h expected=34", rx.c1.hdr.mdata); end
        total++; if (rx.c1.hdr.resp_type !== eRSP_WRLINE) begin bad++; $display("FAIL wr_type: observed=%0h expected=%0h", rx.c1.hdr.resp_type, eRSP_WRLINE); end
        tick();
        total++; if (wr_cnt !== 32'd1) begin bad++; $display("FAIL wr_cnt_1: observed=%0h expected=1", wr_cnt); end
        bd_rd_en = 1'b1; bd_addr = 10'd7; tick(); bd_rd_en = 1'b0;
        total++; if (bd_rdata !== 512'h1) begin bad++; $display("FAIL bd_line7: observed=%0h expected=1", bd_rdata); end
        $display("txn write line 7 mdata 34");

        rsp_stall = 1'b1;
        for (int i = 0; i < 65; i++) begin
            c0_tx.valid = 1'b1; c0_tx.hdr.address = BASE + 42'd5; c0_tx.hdr.mdata = 16'(i);
            tick();
            total++;
            if (rx.c0TxAlmFull !== (i >= 56)) begin
                bad++; $display("FAIL almfull: observed=%0h expected=%0h at i=%0d", rx.c0TxAlmFull, (i >= 56), i);
            end
            total++;
            if (err_flags[0] !== (i == 64)) begin
                bad++; $display("FAIL ovf_err0: observed=%0h expected=%0h at i=%0d", err_flags[0], (i == 64), i);
            end
        end
        c0_tx = '0;
        total++; if (rx.c0.rspValid !== 1'b0) begin bad++; $display("FAIL stall_no_rsp: observed=%0h expected=0", rx.c0.rspValid); end
        total++; if (rx.c1TxAlmFull !== 1'b0) begin bad++; $display("FAIL c1_almfull_idle: observed=%0h expected=0", rx.c1TxAlmFull); end
        $display("txn queued 65 reads under stall");
        rsp_stall = 1'b0;
        got = 0;
        for (int n = 0; n < 200 && got < 64; n++) begin
            tick();
            if (rx.c0.rspValid) begin
                total++;
                if (rx.c0.hdr.mdata !== 16'(got)) begin
                    bad++; $display("FAIL drain_mdata: observed=%0h expected=%0h", rx.c0.hdr.mdata, 16'(got));
                end
                $display("txn drain response mdata %0d", rx.c0.hdr.mdata);
                got++;
            end
        end
        total++; if (got !== 64) begin bad++; $display("FAIL drain_count: observed=%0d expected=64", got); end
        tick();
        total++; if (rx.c0TxAlmFull !== 1'b0) begin bad++; $display("FAIL almfull_clear: observed=%0h expected=0", rx.c0TxAlmFull); end
        total++; if (rd_cnt !== 32'd65) begin bad++; $display("FAIL rd_cnt_65: observed=%0d expected=65", rd_cnt); end

        rsp_stall = 1'b1;
        c0_tx.valid = 1'b1; c0_tx.hdr.address = BASE + 42'd3; c0_tx.hdr.mdata = 16'h21;
        c1_tx.valid = 1'b1; c1_tx.hdr.address = BASE + 42'd3; c1_tx.hdr.mdata = 16'h22; c1_tx.data = pat_c3;
        tick();
        c0_tx = '0; c1_tx = '0; rsp_stall = 1'b0;
        found_at = 0;
        for (int n = 1; n <= 20 && found_at == 0; n++) begin
            tick();
            if (rx.c0.rspValid) found_at = n;
        end
        total++; if (found_at !== 8) begin bad++; $display("FAIL raw_latency: observed=%0d expected=8", found_at); end
        total++; if (rx.c0.data !== pat_c3) begin bad++; $display("FAIL raw_data: observed=%0h expected=%0h", rx.c0.data, pat_c3); end
        total++; if (rx.c0.hdr.mdata !== 16'h21) begin bad++; $display("FAIL raw_mdata: observed=%0h expected=21", rx.c0.hdr.mdata); end
        total++; if (wr_cnt !== 32'd2) begin bad++; $display("FAIL raw_wr_cnt: observed=%0d expected=2", wr_cnt); end
        $display("txn same-cycle read/write line 3");

        c0_tx.valid = 1'b1; c0_tx.hdr.address = BASE + 42'd1024; c0_tx.hdr.mdata = 16'h55;
        tick();
        c0_tx = '0;
        found_at = 0;
        for (int n = 1; n <= 20 && found_at == 0; n++) begin
            tick();
            if (rx.c0.rspValid) found_at = n;
        end
        total++; if (found_at !== 8) begin bad++; $display("FAIL oow_seen: observed=%0d expected=8", found_at); end
        total++; if (rx.c0.data !== 512'h0) begin bad++; $display("FAIL oow_data: observed=%0h expected=0", rx.c0.data); end
        total++; if (rx.c0.hdr.mdata !== 16'h55) begin bad++; $display("FAIL oow_mdata: observed=%0h expected=55", rx.c0.hdr.mdata); end
        total++; if (err_flags !== 3'b101) begin bad++; $display("FAIL oow_err: observed=%0h expected=5", err_flags); end
        $display("txn out-of-window read");

        for (int i = 0; i < 4; i++) begin
            c0_tx.valid = 1'b1; c0_tx.hdr.address = BASE + 42'd5; c0_tx.hdr.mdata = 16'(16'h60 + i);
            tick();
        end
        c0_tx = '0;
        tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        total++; if (rd_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_rd_cnt: observed=%0d expected=0", rd_cnt); end
        total++; if (wr_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_wr_cnt: observed=%0d expected=0", wr_cnt); end
        total++; if (err_flags !== 3'b000) begin bad++; $display("FAIL mid_rst_err: observed=%0h expected=0", err_flags); end
        n_rsp = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rx.c0.rspValid) n_rsp++;
        end
        total++; if (n_rsp !== 0) begin bad++; $display("FAIL mid_rst_no_rsp: observed=%0d expected=0", n_rsp); end
        bd_rd_en = 1'b1; bd_addr = 10'd5; tick();
        total++; if (bd_rdata !== pat_a5) begin bad++; $display("FAIL keep_line5: observed=%0h expected=%0h", bd_rdata, pat_a5); end
        bd_addr = 10'd3; tick(); bd_rd_en = 1'b0;
        total++; if (bd_rdata !== pat_c3) begin bad++; $display("FAIL keep_line3: observed=%0h expected=%0h", bd_rdata, pat_c3); end
        $display("txn reset with reads in flight");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ccip_mem_responder.md
Name: ccip_mem_responder

Overview:
- Host-memory end of the CCI-P link: accepts AFU read (c0) and write (c1) requests and returns eRSP_RDLINE / eRSP_WRLINE responses from an internal line-addressed memory.
- Drives c0TxAlmFull / c1TxAlmFull backpressure.
- Used as the memory side in block-level benches and loopback builds of requestor-type AFUs.
- Provides a backdoor port for preloading and inspecting lines.

Parameters:
- MEM_LINES, 1024, number of 512-bit lines in the memory window (power of 2).
- MEM_BASE, 0, t_ccip_clAddr line address mapped to memory index 0.
- RD_LATENCY, 8, cycles from read-request dequeue to rspValid (min 1).
- REQ_FIFO_DEPTH, 64, depth of each request FIFO (power of 2).
- ALM_FULL_SLACK, 8, free entries remaining when almost-full asserts.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- ccip_c0_tx  in  t_if_ccip_c0_Tx  read requests (valid, hdr.address, hdr.mdata)
- ccip_c1_tx  in  t_if_ccip_c1_Tx  write requests (valid, hdr.address, hdr.mdata, data)
- rsp_stall  in  1  when 1, holds both response outputs off and freezes FIFO dequeue
- ccip_rx  out  t_if_ccip_Rx  c0/c1 responses and c0TxAlmFull/c1TxAlmFull
- bd_wr_en  in  1  backdoor write strobe
- bd_rd_en  in  1  backdoor read strobe
- bd_addr  in  $clog2(MEM_LINES)  backdoor line index
- bd_wdata  in  512  backdoor write data
- bd_rdata  out  512  backdoor read data, valid 1 cycle after bd_rd_en
- rd_cnt  out  32  read responses issued
- wr_cnt  out  32  write responses issued
- err_flags  out  3  sticky: [0] c0 overflow, [1] c1 overflow, [2] out-of-window access

Behaviour:
- Reset state (reset_n low at clk edge):
  - rspValid on both channels 0; all hdr/data fields 0.
  - AlmFull flags 0; FIFOs empty; pipeline cleared; counters, err_flags and bd_rdata 0.
  - Memory contents are retained.
- Reset mid-operation discards every queued and in-flight request; no response is emitted for it.
- Enqueue:
  - c0 valid pushes {address, mdata}; c1 valid pushes {address, mdata, data}.
  - Push into a full FIFO drops the request and sets the matching err_flags bit.
- AlmFull:
  - Registered; asserts the cycle after occupancy >= REQ_FIFO_DEPTH - ALM_FULL_SLACK.
  - Deasserts the cycle after occupancy drops below that threshold.
- Read path (c0):
  - While !rsp_stall, pops at most one request per cycle.
  - Index = address - MEM_BASE (unsigned, truncated to index width).
  - Address outside [MEM_BASE, MEM_BASE+MEM_LINES) returns data 0 and sets err_flags[2]; the response is still issued.
  - Response appears exactly RD_LATENCY cycles after pop, with:
    - resp_type = eRSP_RDLINE, mdata echoed;
    - cl_num = 0, format = 0, data = line.
  - Responses are in request order.
- Read-pipeline stall:
  - rsp_stall freezes the read pipeline in place; rspValid is 0 while stalled.
  - The held response is emitted on the first unstalled cycle.
- Write path (c1):
  - While !rsp_stall, pops at most one request per cycle and writes the line (out-of-window writes are discarded and set err_flags[2]).
  - Issues a c1 response on the next cycle: resp_type = eRSP_WRLINE, mdata echoed.
  - c1 responses are in order.
- Same-cycle read and write to the same line: write takes effect first; the read returns the new data.
- Backdoor access:
  - bd_wr_en has lowest priority; if a c1 write targets the same index in the same cycle, the c1 data wins.
  - bd_rd_en returns the line after any same-cycle write.
- rd_cnt / wr_cnt: increment by 1 on each rspValid and wrap at 2^32.
- Simultaneous enqueue and dequeue on a full FIFO is accepted: dequeue occurs first, so the FIFO is no longer full. No drop.
- Channels are independent; c0 and c1 responses may be valid in the same cycle.

Test Plan:
- Preload line 5 = 0xA5 pattern via backdoor; c0 read addr MEM_BASE+5, mdata 0x12 -> rspValid exactly 8 cycles later, data 0xA5 pattern, mdata 0x12, rd_cnt=1.
- c1 write addr MEM_BASE+7, data 0x1 -> c1 rspValid next cycle with eRSP_WRLINE; bd read of index 7 returns 0x1; wr_cnt=1.
- 64 back-to-back reads with rsp_stall=1 -> c0TxAlmFull asserts after occupancy reaches 56. 65th request sets err_flags[0]. Release stall -> 64 in-order responses, mdata 0..63.
- Read and write to line 3 popped in the same cycle -> read response carries the new write data.
- Read addr MEM_BASE+MEM_LINES -> data 0, response issued, err_flags[2]=1.
- Pulse reset_n low with 4 reads in flight -> no responses afterwards, counters 0, memory still holds preloaded data.
